// File: rtl/fetch_ctrl.sv
// Instruction fetch front end: pc register, 2-entry {pc, instr} queue toward decode,
// redirect handling and a sticky out-of-range halt.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        addr_err
);

  // state | meaning
  // IDLE  | not fetching; redirects still load pc and flush the queue
  // FETCH | pushing one word per cycle while the queue has room
  // HALT  | out-of-range fetch seen; queue drains, only reset exits
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HALT = 2'd2} state_t;

  localparam logic [31:0] IMEM_WORDS_W = 32'(IMEM_WORDS);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        err_q, err_d;
  logic [31:0] ent_pc_q [2];
  logic [31:0] ent_pc_d [2];
  logic [31:0] ent_instr_q [2];
  logic [31:0] ent_instr_d [2];

  logic pop, redirect, want_push, in_range, push, range_fault;

  assign imem_addr = pc_q;
  assign out_valid = (count_q != 2'd0);
  assign out_pc    = out_valid ? ent_pc_q[0] : 32'h0;
  assign out_instr = out_valid ? ent_instr_q[0] : 32'h0;
  assign addr_err  = err_q;

  assign pop         = out_valid && out_ready;
  assign redirect    = redirect_valid && (state_q != HALT);
  assign in_range    = {2'b00, pc_q[31:2]} < IMEM_WORDS_W;
  assign want_push   = (state_q == FETCH) && ((count_q < 2'd2) || pop) && !redirect_valid;
  assign push        = want_push && in_range;
  assign range_fault = want_push && !in_range;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fetch_en) state_d = FETCH;
      FETCH:   if (!fetch_en) state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
    if (range_fault) state_d = HALT;
  end

  always_comb begin
    pc_d           = pc_q;
    count_d        = count_q;
    err_d          = err_q || range_fault;
    ent_pc_d[0]    = ent_pc_q[0];
    ent_pc_d[1]    = ent_pc_q[1];
    ent_instr_d[0] = ent_instr_q[0];
    ent_instr_d[1] = ent_instr_q[1];

    if (redirect) begin
      // A coincident pop has already completed on the output side; just flush.
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = 2'd0;
    end else begin
      if (push) pc_d = pc_q + 32'd4;
      unique case ({push, pop})
        2'b01: begin
          ent_pc_d[0]    = ent_pc_q[1];
          ent_instr_d[0] = ent_instr_q[1];
          count_d        = count_q - 2'd1;
        end
        2'b10: begin
          if (count_q == 2'd0) begin
            ent_pc_d[0]    = pc_q;
            ent_instr_d[0] = imem_rdata;
          end else begin
            ent_pc_d[1]    = pc_q;
            ent_instr_d[1] = imem_rdata;
          end
          count_d = count_q + 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent_pc_d[0]    = pc_q;
            ent_instr_d[0] = imem_rdata;
          end else begin
            ent_pc_d[0]    = ent_pc_q[1];
            ent_instr_d[0] = ent_instr_q[1];
            ent_pc_d[1]    = pc_q;
            ent_instr_d[1] = imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      count_q        <= 2'd0;
      err_q          <= 1'b0;
      ent_pc_q[0]    <= 32'h0;
      ent_pc_q[1]    <= 32'h0;
      ent_instr_q[0] <= 32'h0;
      ent_instr_q[1] <= 32'h0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      count_q        <= count_d;
      err_q          <= err_d;
      ent_pc_q[0]    <= ent_pc_d[0];
      ent_pc_q[1]    <= ent_pc_d[1];
      ent_instr_q[0] <= ent_instr_d[0];
      ent_instr_q[1] <= ent_instr_d[1];
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl; memory word i holds 0x1000+i.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        addr_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = 32'h1000 + {2'b00, imem_addr[31:2]};

  fetch_ctrl #(.RESET_PC(32'h0), .IMEM_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_en(fetch_en),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .addr_err(addr_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    #12;
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_addr",  imem_addr, 32'h0);
    check("rst_pc",    out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_err",   32'(addr_err), 32'h0);

    // streaming
    rst_n = 1'b1; fetch_en = 1'b1; out_ready = 1'b1;
    step();
    check("str_idle_valid", 32'(out_valid), 32'h0);
    check("str_idle_addr",  imem_addr, 32'h0);
    step();
    check("str_valid0", 32'(out_valid), 32'h1);
    check("str_pc0",    out_pc, 32'h0);
    check("str_instr0", out_instr, 32'h1000);
    for (int k = 1; k <= 4; k++) begin
      step();
      check("str_pc",    out_pc, 32'(4 * k));
      check("str_instr", out_instr, 32'(32'h1000 + k));
    end
    check("str_addr", imem_addr, 32'd20);

    // fill to two entries, then async reset mid-cycle
    out_ready = 1'b0;
    step();
    check("fill_addr", imem_addr, 32'd24);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'h0);
    check("arst_addr",  imem_addr, 32'h0);
    check("arst_pc",    out_pc, 32'h0);
    step();
    rst_n = 1'b1;

    // backpressure from reset: five cycles with out_ready low
    step();
    check("bp_idle_valid", 32'(out_valid), 32'h0);
    step();
    check("bp_pc0",   out_pc, 32'h0);
    check("bp_addr1", imem_addr, 32'd4);
    step();
    check("bp_addr2", imem_addr, 32'd8);
    step();
    step();
    check("bp_addr_hold", imem_addr, 32'd8);
    check("bp_head_hold", out_pc, 32'h0);
    out_ready = 1'b1;
    step();
    check("bp_rel_pc4",   out_pc, 32'd4);
    check("sim_addr_adv", imem_addr, 32'd12);
    step();
    check("bp_rel_pc8",    out_pc, 32'd8);
    check("bp_rel_instr8", out_instr, 32'h1002);
    check("sim_addr_adv2", imem_addr, 32'd16);

    // redirect while full, unaligned target
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h43;
    step();
    redirect_valid = 1'b0;
    check("rd_valid", 32'(out_valid), 32'h0);
    check("rd_addr",  imem_addr, 32'h40);
    step();
    check("rd_pc",    out_pc, 32'h40);
    check("rd_instr", out_instr, 32'h1010);
    check("rd_addr2", imem_addr, 32'h44);

    // range limit
    redirect_valid = 1'b1; redirect_pc = 32'hFFC;
    step();
    redirect_valid = 1'b0;
    check("rg_valid0", 32'(out_valid), 32'h0);
    check("rg_addr0",  imem_addr, 32'hFFC);
    step();
    check("rg_pc",    out_pc, 32'hFFC);
    check("rg_instr", out_instr, 32'h13FF);
    check("rg_err0",  32'(addr_err), 32'h0);
    step();
    check("rg_err1",   32'(addr_err), 32'h1);
    check("rg_headpc", out_pc, 32'hFFC);
    check("rg_addr1",  imem_addr, 32'h1000);
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0;
    step();
    redirect_valid = 1'b0;
    check("halt_drain",  32'(out_valid), 32'h0);
    check("halt_rd_ign", imem_addr, 32'h1000);
    step();
    step();
    check("halt_nopush", 32'(out_valid), 32'h0);
    check("halt_err",    32'(addr_err), 32'h1);

    // reset clears the sticky flag; redirect in IDLE
    #2 rst_n = 1'b0; fetch_en = 1'b0;
    #1;
    check("arst_err", 32'(addr_err), 32'h0);
    step();
    rst_n = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h22;
    step();
    redirect_valid = 1'b0; fetch_en = 1'b1;
    check("idle_rd_addr",  imem_addr, 32'h20);
    check("idle_rd_valid", 32'(out_valid), 32'h0);
    step();
    check("idle_fetch_valid", 32'(out_valid), 32'h0);
    step();
    check("idle_rd_pc",    out_pc, 32'h20);
    check("idle_rd_instr", out_instr, 32'h1008);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
